data_path: RTL and testbench



---
 rtl/data_path_pkg.sv | 26 ++
 rtl/data_path_alu.sv | 60 ++++++
 rtl/data_path.sv | 138 +++++++++++++
 tb/tb_data_path.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_path_pkg.sv
// Shared definitions for the single-bus datapath.
//   word_t     : 32-bit datapath word
//   OP_*       : 5-bit ALU opcodes presented on the MUL control input
package data_path_pkg;

    typedef logic [31:0] word_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    // Widen a 32-bit result to the 64-bit Z format.
    function automatic logic [63:0] sign_extend(input word_t w);
        return {{32{w[31]}}, w};
    endfunction

endpackage

// File: rtl/data_path_alu.sv
// Combinational ALU for the single-bus datapath.
//   op     : 5-bit opcode (see data_path_pkg)
//   a      : operand A (Y register)
//   b      : operand B (internal bus)
//   cin    : carry/borrow in for ADD/SUB
//   result : 64-bit result; upper half is the sign extension of the
//            lower half for every operation except MUL
module alu
    import data_path_pkg::*;
(
    input  logic [4:0]  op,
    input  word_t       a,
    input  word_t       b,
    input  logic        cin,
    output logic [63:0] result
);

    word_t              low;
    logic [63:0]        dbl;
    logic [4:0]         sh;
    logic signed [63:0] prod;

    assign sh   = b[4:0];
    // Operands sign-extended explicitly so the product is a true 64-bit signed multiply.
    assign prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

    always_comb begin
        low    = '0;
        dbl    = '0;
        result = '0;
        unique case (op)
            OP_ADD:  low = a + b + {31'b0, cin};
            OP_SUB:  low = a - b - {31'b0, cin};
            OP_SHR:  low = a >> sh;
            OP_SHRA: low = $unsigned($signed(a) >>> sh);
            OP_SHL:  low = a << sh;
            // Rotates via a doubled word: the wanted 32 bits fall out of one shift.
            OP_ROR: begin
                dbl = {a, a} >> sh;
                low = dbl[31:0];
            end
            OP_ROL: begin
                dbl = {a, a} << sh;
                low = dbl[63:32];
            end
            OP_AND:  low = a & b;
            OP_OR:   low = a | b;
            OP_NEG:  low = '0 - b;
            OP_NOT:  low = ~b;
            default: low = '0;
        endcase

        if (op == OP_MUL) begin
            result = prod;
        end else begin
            result = sign_extend(low);
        end
    end

endmodule

// File: rtl/data_path.sv
// Single-bus 32-bit processor datapath.
//   Clock, Clear              : rising-edge clock, async active-high clear
//   PCout..R7out              : bus source selects (priority PC > ZHI > ZLO > MDR > R2..R7)
//   MARin, PCin, MDRin, IRin,
//   Yin, HIin, LOin, R1in..R15in : register load enables from the bus
//   IncPC                     : PC <= PC + 1 (wins over PCin)
//   Read                      : MDR source, 1 = Mdatain, 0 = bus
//   MUL                       : ALU opcode
//   ZHighIn, ZLowIn           : load ALU result halves into ZHI / ZLO
//   Cin                       : ALU carry-in
//   Mdatain                   : memory read data
// No outputs; state is observed hierarchically.
module data_path
    import data_path_pkg::*;
(
    input  logic        Clock,
    input  logic        Clear,
    input  logic        PCout,
    input  logic        ZHighout,
    input  logic        Zlowout,
    input  logic        MDRout,
    input  logic        R2out,
    input  logic        R3out,
    input  logic        R4out,
    input  logic        R5out,
    input  logic        R6out,
    input  logic        R7out,
    input  logic        MARin,
    input  logic        PCin,
    input  logic        MDRin,
    input  logic        IRin,
    input  logic        Yin,
    input  logic        IncPC,
    input  logic        Read,
    input  logic [4:0]  MUL,
    input  logic        R1in,
    input  logic        R2in,
    input  logic        R3in,
    input  logic        R4in,
    input  logic        R5in,
    input  logic        R6in,
    input  logic        R7in,
    input  logic        R8in,
    input  logic        R9in,
    input  logic        R10in,
    input  logic        R11in,
    input  logic        R12in,
    input  logic        R13in,
    input  logic        R14in,
    input  logic        R15in,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        ZHighIn,
    input  logic        ZLowIn,
    input  logic        Cin,
    input  logic [31:0] Mdatain
);

    word_t       r [1:15];
    word_t       pc, ir, mar, mdr, hi, lo, y, zhi, zlo;
    word_t       bus;
    logic [63:0] alu_result;
    logic [15:1] r_in;

    always_comb begin
        r_in     = '0;
        r_in[1]  = R1in;
        r_in[2]  = R2in;
        r_in[3]  = R3in;
        r_in[4]  = R4in;
        r_in[5]  = R5in;
        r_in[6]  = R6in;
        r_in[7]  = R7in;
        r_in[8]  = R8in;
        r_in[9]  = R9in;
        r_in[10] = R10in;
        r_in[11] = R11in;
        r_in[12] = R12in;
        r_in[13] = R13in;
        r_in[14] = R14in;
        r_in[15] = R15in;
    end

    // Priority mux guarantees a single bus driver even if several selects collide.
    always_comb begin
        bus = '0;
        if (PCout)         bus = pc;
        else if (ZHighout) bus = zhi;
        else if (Zlowout)  bus = zlo;
        else if (MDRout)   bus = mdr;
        else if (R2out)    bus = r[2];
        else if (R3out)    bus = r[3];
        else if (R4out)    bus = r[4];
        else if (R5out)    bus = r[5];
        else if (R6out)    bus = r[6];
        else if (R7out)    bus = r[7];
    end

    alu u_alu (
        .op     (MUL),
        .a      (y),
        .b      (bus),
        .cin    (Cin),
        .result (alu_result)
    );

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            pc  <= '0;
            ir  <= '0;
            mar <= '0;
            mdr <= '0;
            hi  <= '0;
            lo  <= '0;
            y   <= '0;
            zhi <= '0;
            zlo <= '0;
            for (int unsigned i = 1; i <= 15; i++) begin
                r[i] <= '0;
            end
        end else begin
            if (IncPC)     pc  <= pc + 32'd1;
            else if (PCin) pc  <= bus;
            if (IRin)      ir  <= bus;
            if (MARin)     mar <= bus;
            if (MDRin)     mdr <= Read ? Mdatain : bus;
            if (HIin)      hi  <= bus;
            if (LOin)      lo  <= bus;
            if (Yin)       y   <= bus;
            if (ZHighIn)   zhi <= alu_result[63:32];
            if (ZLowIn)    zlo <= alu_result[31:0];
            for (int unsigned i = 1; i <= 15; i++) begin
                if (r_in[i]) r[i] <= bus;
            end
        end
    end

endmodule

// File: tb/tb_data_path.sv
module tb_data_path;

    logic        Clock = 1'b0;
    logic        Clear;
    logic        PCout, ZHighout, Zlowout, MDRout;
    logic        R2out, R3out, R4out, R5out, R6out, R7out;
    logic        MARin, PCin, MDRin, IRin, Yin, IncPC, Read;
    logic [4:0]  MUL;
    logic        R1in, R2in, R3in, R4in, R5in, R6in, R7in, R8in;
    logic        R9in, R10in, R11in, R12in, R13in, R14in, R15in;
    logic        HIin, LOin, ZHighIn, ZLowIn, Cin;
    logic [31:0] Mdatain;

    int tests  = 0;
    int failed = 0;

    always #5 Clock = ~Clock;

    data_path dut (
        .Clock(Clock), .Clear(Clear),
        .PCout(PCout), .ZHighout(ZHighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .R2out(R2out), .R3out(R3out), .R4out(R4out), .R5out(R5out),
        .R6out(R6out), .R7out(R7out),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .IncPC(IncPC), .Read(Read), .MUL(MUL),
        .R1in(R1in), .R2in(R2in), .R3in(R3in), .R4in(R4in), .R5in(R5in),
        .R6in(R6in), .R7in(R7in), .R8in(R8in), .R9in(R9in), .R10in(R10in),
        .R11in(R11in), .R12in(R12in), .R13in(R13in), .R14in(R14in), .R15in(R15in),
        .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
        .Cin(Cin), .Mdatain(Mdatain)
    );

    // Reference ALU built from the arithmetic definition of each opcode.
    function automatic logic [63:0] model_alu(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic cin);
        longint      ua = a;
        longint      ub = b;
        longint      sa, sb, pw;
        int          n  = int'(b[4:0]);
        logic [31:0] res = '0;
        pw = 1;
        for (int i = 0; i < n; i++) pw = pw * 2;
        sa = ua; if (a[31]) sa = sa - (longint'(1) << 32);
        sb = ub; if (b[31]) sb = sb - (longint'(1) << 32);
        case (op)
            5'b00011: res = 32'(ua + ub + longint'(cin));
            5'b00100: res = 32'(ua - ub - longint'(cin));
            5'b00101: res = 32'(ua / pw);
            5'b00110: for (int i = 0; i < 32; i++) res[i] = (i + n < 32) ? a[i + n] : a[31];
            5'b00111: res = 32'(ua * pw);
            5'b01000: for (int i = 0; i < 32; i++) res[i] = a[(i + n) % 32];
            5'b01001: for (int i = 0; i < 32; i++) res[(i + n) % 32] = a[i];
            5'b01010: res = a & b;
            5'b01011: res = a | b;
            5'b10000: return 64'(sa * sb);
            5'b10001: res = 32'(longint'(0) - ub);
            5'b10010: res = ~b;
            default:  res = '0;
        endcase
        return {{32{res[31]}}, res};
    endfunction

    task automatic idle();
        {PCout, ZHighout, Zlowout, MDRout} = '0;
        {R2out, R3out, R4out, R5out, R6out, R7out} = '0;
        {MARin, PCin, MDRin, IRin, Yin, IncPC, Read} = '0;
        {R1in, R2in, R3in, R4in, R5in, R6in, R7in, R8in} = '0;
        {R9in, R10in, R11in, R12in, R13in, R14in, R15in} = '0;
        {HIin, LOin, ZHighIn, ZLowIn, Cin} = '0;
        MUL = '0;
    endtask

    task automatic set_out(input int k);
        case (k)
            2: R2out = 1'b1;
            3: R3out = 1'b1;
            4: R4out = 1'b1;
            5: R5out = 1'b1;
            6: R6out = 1'b1;
            7: R7out = 1'b1;
            default: ;
        endcase
    endtask

    task automatic set_in(input int k);
        case (k)
            2: R2in = 1'b1;
            3: R3in = 1'b1;
            4: R4in = 1'b1;
            5: R5in = 1'b1;
            6: R6in = 1'b1;
            7: R7in = 1'b1;
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Mdatain -> MDR -> bus -> Rk
    task automatic load_reg(input int k, input logic [31:0] v);
        idle(); Mdatain = v; Read = 1'b1; MDRin = 1'b1; tick();
        idle(); MDRout = 1'b1; set_in(k); tick();
        idle();
    endtask

    // Ra -> Y; Rb op -> Z; ZLO -> Rd
    task automatic alu_op(input int ra, input int rb, input logic [4:0] op,
                          input logic c, input int rd);
        idle(); set_out(ra); Yin = 1'b1; tick();
        idle(); set_out(rb); MUL = op; Cin = c; ZLowIn = 1'b1; ZHighIn = 1'b1; tick();
        idle(); Zlowout = 1'b1; set_in(rd); tick();
        idle();
    endtask

    task automatic test_reset();
        idle(); Clear = 1'b1;
        Mdatain = 32'hDEAD_BEEF; Read = 1'b1; MDRin = 1'b1; IncPC = 1'b1; Yin = 1'b1;
        tick(); tick();
        tests++; if (dut.pc !== 32'h0) begin failed++; $display("FAIL reset_pc got %h want 0", dut.pc); end
        tests++; if (dut.mdr !== 32'h0) begin failed++; $display("FAIL reset_mdr got %h want 0", dut.mdr); end
        tests++; if (dut.zlo !== 32'h0 || dut.zhi !== 32'h0 || dut.y !== 32'h0)
            begin failed++; $display("FAIL reset_yz got y=%h zhi=%h zlo=%h want 0", dut.y, dut.zhi, dut.zlo); end
        idle(); Clear = 1'b0; tick();
    endtask

    task automatic test_mul_basic();
        load_reg(2, 32'h12);
        load_reg(6, 32'h14);
        alu_op(2, 6, 5'b10000, 1'b0, 2);
        tests++; if (dut.r[2] !== 32'h168) begin failed++; $display("FAIL mul_r2 got %h want 00000168", dut.r[2]); end
        tests++; if (dut.r[6] !== 32'h14) begin failed++; $display("FAIL mul_r6 got %h want 00000014", dut.r[6]); end
    endtask

    task automatic test_mul_signed();
        load_reg(3, 32'hFFFF_FFFE);
        load_reg(4, 32'h3);
        alu_op(3, 4, 5'b10000, 1'b0, 5);
        tests++; if (dut.zhi !== 32'hFFFF_FFFF) begin failed++; $display("FAIL mul_zhi got %h want ffffffff", dut.zhi); end
        tests++; if (dut.zlo !== 32'hFFFF_FFFA) begin failed++; $display("FAIL mul_zlo got %h want fffffffa", dut.zlo); end
    endtask

    task automatic test_add_sub();
        load_reg(5, 32'h7FFF_FFFF);
        load_reg(7, 32'h1);
        alu_op(5, 7, 5'b00011, 1'b1, 2);
        tests++; if (dut.zlo !== 32'h8000_0001) begin failed++; $display("FAIL add_zlo got %h want 80000001", dut.zlo); end
        tests++; if (dut.zhi !== 32'hFFFF_FFFF) begin failed++; $display("FAIL add_zhi got %h want ffffffff", dut.zhi); end
        alu_op(5, 7, 5'b00100, 1'b0, 2);
        tests++; if (dut.zlo !== 32'h7FFF_FFFE) begin failed++; $display("FAIL sub_zlo got %h want 7ffffffe", dut.zlo); end
        tests++; if (dut.r[2] !== 32'h7FFF_FFFE) begin failed++; $display("FAIL sub_r2 got %h want 7ffffffe", dut.r[2]); end
    endtask

    task automatic test_pc();
        load_reg(2, 32'hFFFF_FFFF);
        load_reg(3, 32'h1234);
        idle(); R2out = 1'b1; PCin = 1'b1; tick();
        tests++; if (dut.pc !== 32'hFFFF_FFFF) begin failed++; $display("FAIL pc_load got %h want ffffffff", dut.pc); end
        idle(); R3out = 1'b1; PCin = 1'b1; IncPC = 1'b1; tick();
        tests++; if (dut.pc !== 32'h0) begin failed++; $display("FAIL pc_wrap got %h want 0", dut.pc); end
        idle(); IncPC = 1'b1; tick();
        idle(); PCout = 1'b1; MDRout = 1'b1; #1;
        tests++; if (dut.bus !== 32'h1) begin failed++; $display("FAIL bus_priority got %h want 00000001", dut.bus); end
        R4in = 1'b1; tick(); idle();
        tests++; if (dut.r[4] !== 32'h1) begin failed++; $display("FAIL pc_to_r4 got %h want 00000001", dut.r[4]); end
    endtask

    task automatic test_mdr();
        load_reg(2, 32'h55);
        idle(); R2out = 1'b1; MDRin = 1'b1; Read = 1'b0; Mdatain = 32'hAA; tick();
        tests++; if (dut.mdr !== 32'h55) begin failed++; $display("FAIL mdr_bus got %h want 00000055", dut.mdr); end
        idle(); R2out = 1'b1; MDRin = 1'b1; Read = 1'b1; Mdatain = 32'hAA; tick();
        tests++; if (dut.mdr !== 32'hAA) begin failed++; $display("FAIL mdr_mem got %h want 000000aa", dut.mdr); end
        idle();
    endtask

    // ZLO is both bus source and destination: it must take old ZLO + Y.
    task automatic test_same_cycle();
        load_reg(2, 32'h5);
        load_reg(3, 32'h1);
        idle(); R3out = 1'b1; Yin = 1'b1; tick();
        idle(); R2out = 1'b1; MUL = 5'b00011; ZLowIn = 1'b1; tick();
        idle(); Zlowout = 1'b1; MUL = 5'b00011; ZLowIn = 1'b1; tick();
        tests++; if (dut.zlo !== 32'h7) begin failed++; $display("FAIL same_cycle_zlo got %h want 00000007", dut.zlo); end
        idle();
    endtask

    task automatic test_clear_mid();
        load_reg(2, 32'h9);
        load_reg(3, 32'h4);
        idle(); R2out = 1'b1; Yin = 1'b1; tick();
        tests++; if (dut.y !== 32'h9) begin failed++; $display("FAIL clr_y_pre got %h want 00000009", dut.y); end
        idle(); R3out = 1'b1; MUL = 5'b00011; ZLowIn = 1'b1; ZHighIn = 1'b1;
        #2 Clear = 1'b1;
        #1;
        tests++; if (dut.y !== 32'h0 || dut.zlo !== 32'h0 || dut.zhi !== 32'h0)
            begin failed++; $display("FAIL clr_async_yz got y=%h zhi=%h zlo=%h want 0", dut.y, dut.zhi, dut.zlo); end
        tests++; if (dut.r[2] !== 32'h0 || dut.r[3] !== 32'h0)
            begin failed++; $display("FAIL clr_async_r got r2=%h r3=%h want 0", dut.r[2], dut.r[3]); end
        tick();
        Clear = 1'b0;
        idle(); Zlowout = 1'b1; R2in = 1'b1; tick();
        tests++; if (dut.r[2] !== 32'h0) begin failed++; $display("FAIL clr_writeback got %h want 0", dut.r[2]); end
        idle();
    endtask

    task automatic test_random();
        logic [4:0]  ops [15] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                  5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b10000,
                                  5'b10001, 5'b10010, 5'b00000, 5'b01100, 5'b11111};
        logic [31:0] a, b;
        logic [4:0]  op;
        logic        c;
        logic [63:0] exp;
        for (int it = 0; it < 40; it++) begin
            a  = $urandom;
            b  = $urandom;
            if (it % 5 == 0) b[4:0] = 5'd0;
            op = ops[$urandom_range(0, 14)];
            c  = 1'($urandom_range(0, 1));
            exp = model_alu(op, a, b, c);
            load_reg(3, a);
            load_reg(4, b);
            alu_op(3, 4, op, c, 5);
            tests++;
            if ({dut.zhi, dut.zlo} !== exp) begin
                failed++;
                $display("FAIL rand_z op=%b a=%h b=%h cin=%b got %h_%h want %h",
                         op, a, b, c, dut.zhi, dut.zlo, exp);
            end
            tests++;
            if (dut.r[5] !== exp[31:0] || dut.r[4] !== b) begin
                failed++;
                $display("FAIL rand_rd op=%b got r5=%h r4=%h want r5=%h r4=%h",
                         op, dut.r[5], dut.r[4], exp[31:0], b);
            end
        end
    endtask

    initial begin
        idle();
        Clear   = 1'b1;
        Mdatain = '0;
        test_reset();
        test_mul_basic();
        test_mul_signed();
        test_add_sub();
        test_pc();
        test_mdr();
        test_same_cycle();
        test_clear_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
